// File: rtl/pcie_reg_space_pkg.sv
// Shared constants and FSM state types for the PCIe register-space AXI4-Lite slave.
package pcie_reg_space_pkg;

  localparam logic [1:0]  RESP_OKAY       = 2'b00;
  localparam logic [1:0]  RESP_SLVERR     = 2'b10;
  localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0001;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/pcie_reg_space_wstrb_merge.sv
// Byte-lane merge: each byte of the result takes wdata where its strobe is set,
// otherwise keeps the old register byte.
module pcie_reg_space_wstrb_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] merged
);

  // Select each byte lane independently from old or new data.
  always_comb begin
    merged = old_data;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/pcie_reg_space_axil_slave.sv
// AXI4-Lite slave hosting the PCIe control/status register bank.
// Independent write and read FSMs, one transaction of each kind in flight.
// Highest register index is a read-only version register.
// Build option: PCIE_REG_SPACE_SLVERR_EN makes out-of-range accesses answer SLVERR.
//
// Handshake rule: a channel transfers on a rising edge where VALID and READY are
// both high; READY depends only on FSM state and the post-reset enable flag, and
// a VALID response is held with stable payload until its READY is seen.
module pcie_reg_space_axil_slave
  import pcie_reg_space_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          C_NUM_REGS         = 8,
  parameter logic [31:0] C_VERSION          = VERSION_DEFAULT
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [32*C_NUM_REGS-1:0]          reg_out,
  output logic [C_NUM_REGS-1:0]             reg_wr_pulse,
  output wr_state_t                         wr_state,
  output rd_state_t                         rd_state
);

  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

`ifdef PCIE_REG_SPACE_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Ready enable: READY outputs stay low until two edges after reset release.
  // ---------------------------------------------------------------------------
  logic rst_seen_q, ready_en;

  // Two-stage enable so the first cycle after release still reports not-ready.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_seen_q <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      rst_seen_q <= 1'b1;
      ready_en   <= rst_seen_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  logic [31:0] regs [C_NUM_REGS];

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs[g];
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  wr_state_t       wr_state_q, wr_state_d;
  logic            aw_hs, w_hs, wr_commit;
  logic [IW-1:0]   aw_idx_q, commit_idx;
  logic [31:0]     wdata_q, commit_data, old_data, merged_data;
  logic [3:0]      wstrb_q, commit_strb;
  logic            wr_in_range, wr_writable;
  logic [C_NUM_REGS-1:0] wr_onehot;

  assign S_AXI_AWREADY = ready_en && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_D);
  assign S_AXI_WREADY  = ready_en && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_A);
  assign S_AXI_BVALID  = (wr_state_q == W_RESP);
  assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;
  assign wr_state      = wr_state_q;

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wr_state_q <= W_IDLE;
    else          wr_state_q <= wr_state_d;
  end

  // Write FSM next state: gather address and data in either order, then respond.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = W_RESP;
        else if (aw_hs)    wr_state_d = W_HAVE_A;
        else if (w_hs)     wr_state_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)         wr_state_d = W_RESP;
      W_HAVE_D: if (aw_hs)        wr_state_d = W_RESP;
      W_RESP:   if (S_AXI_BREADY) wr_state_d = W_IDLE;
      default:                    wr_state_d = W_IDLE;
    endcase
  end

  // The commit edge is the one that enters W_RESP.
  assign wr_commit = (wr_state_q != W_RESP) && (wr_state_d == W_RESP);

  // Hold whichever half of the write arrived first.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // The half arriving on the commit edge comes straight from the bus.
  assign commit_idx  = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
  assign commit_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign commit_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign wr_in_range = {{(32-IW){1'b0}}, commit_idx} < 32'(C_NUM_REGS);
  assign wr_writable = {{(32-IW){1'b0}}, commit_idx} < 32'(C_NUM_REGS - 1);

  // Decode the target register and fetch its current value for merging.
  always_comb begin
    old_data  = '0;
    wr_onehot = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (commit_idx == IW'(k)) begin
        old_data     = regs[k];
        wr_onehot[k] = wr_writable;
      end
    end
  end

  pcie_reg_space_wstrb_merge u_merge (
    .old_data (old_data),
    .wdata    (commit_data),
    .wstrb    (commit_strb),
    .merged   (merged_data)
  );

  // Register bank update; the version register keeps its reset value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < C_NUM_REGS - 1; k++) regs[k] <= '0;
      regs[C_NUM_REGS-1] <= C_VERSION;
    end else if (wr_commit) begin
      for (int k = 0; k < C_NUM_REGS - 1; k++) begin
        if (wr_onehot[k]) regs[k] <= merged_data;
      end
    end
  end

  // One-cycle commit pulse and the write response code.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      reg_wr_pulse <= '0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      reg_wr_pulse <= wr_commit ? wr_onehot : '0;
      if (wr_commit) S_AXI_BRESP <= (SLVERR_EN && !wr_in_range) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_t     rd_state_q, rd_state_d;
  logic          ar_hs, rd_in_range;
  logic [IW-1:0] rd_idx;
  logic [31:0]   rd_sel;

  assign S_AXI_ARREADY = ready_en && (rd_state_q == R_IDLE);
  assign S_AXI_RVALID  = (rd_state_q == R_DATA);
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_state      = rd_state_q;
  assign rd_idx        = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_in_range   = {{(32-IW){1'b0}}, rd_idx} < 32'(C_NUM_REGS);

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rd_state_q <= R_IDLE;
    else          rd_state_q <= rd_state_d;
  end

  // Read FSM next state: accept an address, then hold data until taken.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs)        rd_state_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
      default:                   rd_state_d = R_IDLE;
    endcase
  end

  // Read mux; out-of-range indices yield zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (rd_idx == IW'(k)) rd_sel = regs[k];
    end
  end

  // Capture read data at the AR handshake (pre-write value on a same-edge commit).
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RDATA <= rd_sel;
      S_AXI_RRESP <= (SLVERR_EN && !rd_in_range) ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule
